// File: rtl/mux_arb_reg.sv
// ---------------------------------------------------------------------------
// mux_arb_reg
//   N-channel, WIDTH-bit datapath selector with a single registered output
//   stage. Every input channel and the output use a valid/ready handshake.
//   The channel is chosen either by a fixed selector (mode = 0) or by
//   round-robin arbitration among the valid channels (mode = 1).
//
// Ports
//   clk        in   1        rising-edge clock
//   reset_n    in   1        asynchronous assert, synchronous release, active low
//   mode       in   1        0 = fixed select, 1 = round-robin
//   selector   in   SEL_W    channel index used when mode = 0
//   in_valid   in   N        bit i: channel i presents data
//   in_data    in   N*WIDTH  channel i occupies [i*WIDTH +: WIDTH]
//   in_ready   out  N        one-hot or zero: channel i transfers if in_valid[i]
//   out_valid  out  1        output register holds valid data
//   out_data   out  WIDTH    registered data
//   out_sel    out  SEL_W    index of the channel that produced out_data
//   out_ready  in   1        sink accepts out_data this cycle
// ---------------------------------------------------------------------------
module mux_arb_reg #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 mode,
    input  logic [SEL_W-1:0]     selector,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_W-1:0]     out_sel,
    input  logic                 out_ready
);

    // Round-robin search: first valid channel after ptr, wrapping modulo N.
    // Returns {found, index}. The loop runs from the farthest candidate to
    // the nearest so the nearest valid channel is the last one written.
    function automatic logic [SEL_W:0] rr_pick(
        input logic [N-1:0]     valid,
        input logic [SEL_W-1:0] ptr
    );
        logic [SEL_W:0]   res;
        logic [31:0]      pos;
        logic [SEL_W-1:0] idx;
        res = {1'b0, {SEL_W{1'b0}}};
        for (int k = N; k >= 1; k--) begin
            pos = (32'(ptr) + 32'(k)) % 32'(N);
            idx = pos[SEL_W-1:0];
            if (valid[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Fixed-select grant check: a selector outside 0..N-1 never grants.
    function automatic logic fixed_ok(
        input logic [N-1:0]     valid,
        input logic [SEL_W-1:0] sel
    );
        logic ok;
        if (32'(sel) < 32'(N)) begin
            ok = valid[sel];
        end else begin
            ok = 1'b0;
        end
        return ok;
    endfunction

    logic             out_valid_r;
    logic [WIDTH-1:0] out_data_r;
    logic [SEL_W-1:0] out_sel_r;
    logic [SEL_W-1:0] rr_ptr_r;

    logic             accept_s;
    logic             grant_valid_s;
    logic [SEL_W-1:0] grant_idx_s;
    logic [SEL_W:0]   rr_res_s;
    logic [N-1:0]     ready_s;
    logic             xfer_s;

    // The register can take a new word when it is empty or being drained now.
    assign accept_s = !out_valid_r || out_ready;

    assign rr_res_s = rr_pick(in_valid, rr_ptr_r);

    // Grant selection; mode is applied in the same cycle it changes.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_idx_s   = {SEL_W{1'b0}};
        case (mode)
            1'b0: begin
                grant_valid_s = fixed_ok(in_valid, selector);
                grant_idx_s   = selector;
            end
            1'b1: begin
                grant_valid_s = rr_res_s[SEL_W];
                grant_idx_s   = rr_res_s[SEL_W-1:0];
            end
            default: begin
                grant_valid_s = 1'b0;
                grant_idx_s   = {SEL_W{1'b0}};
            end
        endcase
    end

    // One-hot ready toward the granted channel when the register can accept.
    // A grant already implies in_valid of that channel, so ready doubles as
    // the transfer strobe.
    always_comb begin
        ready_s = {N{1'b0}};
        if (grant_valid_s && accept_s) begin
            ready_s[grant_idx_s] = 1'b1;
        end else begin
            ready_s = {N{1'b0}};
        end
    end

    assign xfer_s   = grant_valid_s && accept_s;
    // Ready is forced low while reset is asserted, independent of the clock.
    assign in_ready = ready_s & {N{reset_n}};

    // Output register: load on transfer (also during a drain, so no bubble),
    // clear valid on a drain-only cycle, hold otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {WIDTH{1'b0}};
            out_sel_r   <= {SEL_W{1'b0}};
        end else if (xfer_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= in_data[grant_idx_s*WIDTH +: WIDTH];
            out_sel_r   <= grant_idx_s;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
            out_data_r  <= out_data_r;
            out_sel_r   <= out_sel_r;
        end else begin
            out_valid_r <= out_valid_r;
            out_data_r  <= out_data_r;
            out_sel_r   <= out_sel_r;
        end
    end

    // Round-robin pointer: starts at N-1 so channel 0 wins first after reset;
    // only round-robin transfers move it, and it survives mode changes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_r <= SEL_W'(N - 1);
        end else if (xfer_s && mode) begin
            rr_ptr_r <= grant_idx_s;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_sel   = out_sel_r;

endmodule

// File: tb/tb_mux_arb_reg.sv
// ---------------------------------------------------------------------------
// tb_mux_arb_reg
//   Directed bench for mux_arb_reg. A 4-channel instance is checked through a
//   scoreboard: each expected transfer is queued by the stimulus, and a
//   monitor pops and compares whenever the sink drains a word. A 3-channel
//   instance covers the out-of-range selector. Inputs change #1 after the
//   rising edge; the monitor samples on the falling edge.
// ---------------------------------------------------------------------------
module tb_mux_arb_reg;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  s;
    } exp_t;

    logic clk;
    logic reset_n;

    // 4-channel instance
    logic         mode;
    logic [1:0]   selector;
    logic [3:0]   in_valid;
    logic [127:0] in_data;
    logic [3:0]   in_ready;
    logic         out_valid;
    logic [31:0]  out_data;
    logic [1:0]   out_sel;
    logic         out_ready;
    logic [31:0]  ch_data [4];

    // 3-channel instance
    logic         mode3;
    logic [1:0]   selector3;
    logic [2:0]   in_valid3;
    logic [95:0]  in_data3;
    logic [2:0]   in_ready3;
    logic         out_valid3;
    logic [31:0]  out_data3;
    logic [1:0]   out_sel3;
    logic         out_ready3;

    exp_t exp_q [$];
    int   n_checks = 0;
    int   n_pass   = 0;

    assign in_data  = {ch_data[3], ch_data[2], ch_data[1], ch_data[0]};
    assign in_data3 = {32'h3333_0002, 32'h3333_0001, 32'h3333_0000};

    mux_arb_reg #(.WIDTH(32), .N(4)) dut4 (
        .clk       (clk),
        .reset_n   (reset_n),
        .mode      (mode),
        .selector  (selector),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    mux_arb_reg #(.WIDTH(32), .N(3)) dut3 (
        .clk       (clk),
        .reset_n   (reset_n),
        .mode      (mode3),
        .selector  (selector3),
        .in_valid  (in_valid3),
        .in_data   (in_data3),
        .in_ready  (in_ready3),
        .out_valid (out_valid3),
        .out_data  (out_data3),
        .out_sel   (out_sel3),
        .out_ready (out_ready3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic [1:0] s);
        exp_t e;
        e.d = d;
        e.s = s;
        exp_q.push_back(e);
    endtask

    // Monitor: every word the sink accepts must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                check("sb_data", 64'(out_data), 64'(e.d));
                check("sb_sel",  64'(out_sel),  64'(e.s));
            end
        end
    end

    initial begin
        logic [1:0] rr_seq [3];
        rr_seq[0] = 2'd0;
        rr_seq[1] = 2'd2;
        rr_seq[2] = 2'd0;

        reset_n    = 1'b0;
        mode       = 1'b0;
        selector   = 2'd0;
        in_valid   = 4'b0000;
        out_ready  = 1'b0;
        ch_data[0] = 32'hCAFE_0000;
        ch_data[1] = 32'hCAFE_0001;
        ch_data[2] = 32'hCAFE_0002;
        ch_data[3] = 32'hCAFE_0003;
        mode3      = 1'b0;
        selector3  = 2'd0;
        in_valid3  = 3'b000;
        out_ready3 = 1'b0;

        // Reset state, with requests pending so in_ready=0 is meaningful
        repeat (3) tick();
        mode      = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        settle();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data",  64'(out_data),  64'd0);
        check("rst_out_sel",   64'(out_sel),   64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd0);
        reset_n = 1'b1;
        settle();
        check("rr_first_ready", 64'(in_ready), 64'b0001);

        // Round-robin with all channels valid: 0,1,2,3,0,1,2,3 back to back
        for (int k = 0; k < 8; k++) begin
            settle();
            check("rr_seq_ready", 64'(in_ready), 64'(4'b0001 << (k % 4)));
            push(ch_data[k % 4], 2'(k % 4));
            tick();
            check("rr_tput_valid", 64'(out_valid), 64'd1);
        end
        in_valid = 4'b0000;
        settle();
        check("idle_ready", 64'(in_ready), 64'd0);
        tick();
        check("idle_drained", 64'(out_valid), 64'd0);

        // Fixed select of channel 2
        mode     = 1'b0;
        selector = 2'd2;
        in_valid = 4'b1111;
        settle();
        check("fix_ready", 64'(in_ready), 64'b0100);
        push(32'hCAFE_0002, 2'd2);
        tick();
        check("fix_data", 64'(out_data), 64'hCAFE_0002);
        check("fix_sel",  64'(out_sel),  64'd2);
        in_valid = 4'b0000;
        tick();

        // Round-robin skips idle channels; pointer still 3 after the fixed transfer
        mode     = 1'b1;
        in_valid = 4'b0101;
        for (int k = 0; k < 3; k++) begin
            settle();
            check("rr_skip_ready", 64'(in_ready), 64'(4'b0001 << rr_seq[k]));
            push(ch_data[rr_seq[k]], rr_seq[k]);
            tick();
        end
        in_valid = 4'b0000;
        tick();

        // Backpressure: hold for 3 cycles, then drain and load on the same edge
        mode      = 1'b0;
        selector  = 2'd1;
        in_valid  = 4'b0010;
        out_ready = 1'b0;
        settle();
        check("bp_load_ready", 64'(in_ready), 64'b0010);
        push(32'hCAFE_0001, 2'd1);
        tick();
        selector = 2'd3;
        in_valid = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            settle();
            check("stall_ready", 64'(in_ready),  64'd0);
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_data",  64'(out_data),  64'hCAFE_0001);
            check("stall_sel",   64'(out_sel),   64'd1);
            tick();
        end
        ch_data[1] = 32'h1111_BEEF;
        selector   = 2'd1;
        out_ready  = 1'b1;
        settle();
        check("nobubble_ready", 64'(in_ready), 64'b0010);
        push(32'h1111_BEEF, 2'd1);
        tick();
        check("nobubble_valid", 64'(out_valid), 64'd1);
        check("nobubble_data",  64'(out_data),  64'h1111_BEEF);
        in_valid = 4'b0000;
        tick();
        check("drain_valid", 64'(out_valid), 64'd0);
        check("drain_data",  64'(out_data),  64'h1111_BEEF);
        check("drain_sel",   64'(out_sel),   64'd1);

        // N=3: selector 3 is out of range and never grants
        selector3  = 2'd1;
        in_valid3  = 3'b111;
        out_ready3 = 1'b1;
        settle();
        check("n3_ready1", 64'(in_ready3), 64'b010);
        tick();
        check("n3_data1", 64'(out_data3), 64'h3333_0001);
        check("n3_sel1",  64'(out_sel3),  64'd1);
        selector3 = 2'd3;
        settle();
        check("n3_oor_ready", 64'(in_ready3), 64'd0);
        tick();
        check("n3_oor_valid_a", 64'(out_valid3), 64'd0);
        tick();
        check("n3_oor_valid_b", 64'(out_valid3), 64'd0);
        selector3 = 2'd2;
        settle();
        check("n3_ready2", 64'(in_ready3), 64'b100);
        tick();
        check("n3_data2", 64'(out_data3), 64'h3333_0002);
        check("n3_sel2",  64'(out_sel3),  64'd2);
        in_valid3 = 3'b000;
        tick();

        // Mid-stream reset discards the held word; afterwards channel 0 wins first
        mode      = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        tick();
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        reset_n   = 1'b0;
        out_ready = 1'b1;
        settle();
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_data",  64'(out_data),  64'd0);
        check("mid_rst_sel",   64'(out_sel),   64'd0);
        check("mid_rst_ready", 64'(in_ready),  64'd0);
        tick();
        reset_n = 1'b1;
        settle();
        check("post_rst_ready", 64'(in_ready), 64'b0001);
        push(32'hCAFE_0000, 2'd0);
        tick();
        in_valid = 4'b0000;
        tick();
        tick();

        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
